// File: rtl/axis_pkt_pkg.sv
// Shared types and constants for the store-and-forward AXI4-Stream packet FIFO.
package axis_pkt_pkg;

  typedef enum logic {
    ST_STORE,
    ST_FORCE
  } rel_state_t;

  localparam logic [15:0] OVERSIZE_MAX = 16'hFFFF;

endpackage

// File: rtl/axis_pkt_fifo_mem.sv
// DEPTH x (DATA_W+1) beat storage: synchronous write port, asynchronous read port.
module axis_pkt_fifo_mem #(
  parameter int  DATA_W = 32,
  parameter int  DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DATA_W:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [DATA_W:0] rdata
);

  logic [DATA_W:0] mem_q [DEPTH];

  // NOTE: the storage array has no reset; the pointers and counters alone decide
  // which entries are meaningful, so clearing it would only add reset fan-out.
  // NOTE: sequential state is always updated with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI4-Stream packet FIFO: a packet is released only once its
// TLAST beat is stored, with a cut-through fallback when a packet outgrows DEPTH.
module axis_pkt_fifo
  import axis_pkt_pkg::*;
#(
  parameter int  DATA_W = 32,
  parameter int  DEPTH  = 16,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [CNT_W-1:0]  level,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [15:0]       oversize_cnt
);

  localparam int               AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [AW:0]      PTR_ONE = (AW + 1)'(1);

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] level_q, level_d, pkt_count_q, pkt_count_d;
  logic [15:0]      oversize_q, oversize_d;
  rel_state_t       state_q, state_d;

  entry_t wr_entry, head;
  logic   empty, full, force_rel, wr, rd, wr_last, rd_last;

  // Extra pointer MSB distinguishes a full buffer from an empty one.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign force_rel = (state_q == ST_FORCE);

  assign s_axis_tready = !full;
  assign m_axis_tvalid = !empty && ((pkt_count_q != '0) || force_rel);
  assign wr            = s_axis_tvalid && s_axis_tready;
  assign rd            = m_axis_tvalid && m_axis_tready;
  assign wr_last       = wr && s_axis_tlast;
  assign rd_last       = rd && head.last;

  assign wr_entry     = '{last: s_axis_tlast, data: s_axis_tdata};
  assign m_axis_tdata = head.data;
  assign m_axis_tlast = head.last && m_axis_tvalid;

  assign level        = level_q;
  assign pkt_count    = pkt_count_q;
  assign oversize_cnt = oversize_q;

  axis_pkt_fifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk  (aclk),
    .we   (wr),
    .waddr(wr_ptr_q[AW-1:0]),
    .wdata(wr_entry),
    .raddr(rd_ptr_q[AW-1:0]),
    .rdata(head)
  );

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    pkt_count_d = pkt_count_q;
    oversize_d  = oversize_q;
    state_d     = state_q;

    if (wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd) rd_ptr_d = rd_ptr_q + PTR_ONE;

    if (wr && !rd)      level_d = level_q + CNT_ONE;
    else if (!wr && rd) level_d = level_q - CNT_ONE;

    if (wr_last && !rd_last)      pkt_count_d = pkt_count_q + CNT_ONE;
    else if (!wr_last && rd_last) pkt_count_d = pkt_count_q - CNT_ONE;

    // A full buffer holding no complete packet can never drain in STORE mode.
    case (state_q)
      ST_STORE: begin
        if ((level_q == DEPTH_C) && (pkt_count_q == '0)) begin
          state_d = ST_FORCE;
          if (oversize_q != OVERSIZE_MAX) oversize_d = oversize_q + 16'd1;
        end
      end
      ST_FORCE: begin
        if (rd_last) state_d = ST_STORE;
      end
      default: state_d = ST_STORE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pkt_count_q <= '0;
      oversize_q  <= '0;
      state_q     <= ST_STORE;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pkt_count_q <= pkt_count_d;
      oversize_q  <= oversize_d;
      state_q     <= state_d;
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Self-checking bench for axis_pkt_fifo: a queue-based packet model predicts every
// output each cycle while scenario tasks drive directed and randomized traffic.
module tb_axis_pkt_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready = 1'b0;
  logic [CNT_W-1:0]  level;
  logic [CNT_W-1:0]  pkt_count;
  logic [15:0]       oversize_cnt;

  always #5 aclk = ~aclk;

  axis_pkt_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .level        (level),
    .pkt_count    (pkt_count),
    .oversize_cnt (oversize_cnt)
  );

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  int    tests_run = 0;
  int    tests_failed = 0;
  beat_t mq[$];     // beats the model says are stored, head first
  beat_t got[$];    // beats the model says were delivered
  beat_t exp_q[$];  // beats the scenario sent, in order
  int    m_pkts = 0;
  bit    m_force = 1'b0;
  int    m_ovs = 0;
  int    ready_mode = 0;  // 0 never, 1 always, 2 low2/high3, 3 random
  int    cyc = 0;
  bit    last_wr = 1'b0;

  task automatic model_reset();
    mq.delete();
    got.delete();
    exp_q.delete();
    m_pkts  = 0;
    m_force = 1'b0;
    m_ovs   = 0;
  endtask

  // Advances one clock: drives the slave ready, compares every output with the
  // model mid-cycle, then applies the handshakes of this cycle to the model.
  task automatic cycle();
    bit    exp_ready, exp_valid, wr, rd;
    beat_t b;
    case (ready_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      2:       m_axis_tready = ((cyc % 5) >= 2);
      default: m_axis_tready = ($urandom_range(0, 1) == 1);
    endcase
    exp_ready = (mq.size() != DEPTH);
    exp_valid = (mq.size() != 0) && ((m_pkts != 0) || m_force);
    @(negedge aclk);
    tests_run++;
    if (level !== CNT_W'(mq.size())) begin
      tests_failed++;
      $display("FAIL level cyc %0d: got %0d expected %0d", cyc, level, mq.size());
    end
    tests_run++;
    if (pkt_count !== CNT_W'(m_pkts)) begin
      tests_failed++;
      $display("FAIL pkt_count cyc %0d: got %0d expected %0d", cyc, pkt_count, m_pkts);
    end
    tests_run++;
    if (s_axis_tready !== exp_ready) begin
      tests_failed++;
      $display("FAIL s_tready cyc %0d: got %b expected %b", cyc, s_axis_tready, exp_ready);
    end
    tests_run++;
    if (m_axis_tvalid !== exp_valid) begin
      tests_failed++;
      $display("FAIL m_tvalid cyc %0d: got %b expected %b", cyc, m_axis_tvalid, exp_valid);
    end
    tests_run++;
    if (oversize_cnt !== 16'(m_ovs)) begin
      tests_failed++;
      $display("FAIL oversize_cnt cyc %0d: got %0d expected %0d", cyc, oversize_cnt, m_ovs);
    end
    if (exp_valid) begin
      tests_run++;
      if (m_axis_tdata !== mq[0].data || m_axis_tlast !== mq[0].last) begin
        tests_failed++;
        $display("FAIL head cyc %0d: got %h/%b expected %h/%b", cyc, m_axis_tdata,
                 m_axis_tlast, mq[0].data, mq[0].last);
      end
    end
    wr = s_axis_tvalid && exp_ready;
    rd = m_axis_tready && exp_valid;
    @(posedge aclk);
    if (!m_force && mq.size() == DEPTH && m_pkts == 0) begin
      m_force = 1'b1;
      if (m_ovs < 65535) m_ovs++;
    end else if (m_force && rd && mq[0].last) begin
      m_force = 1'b0;
    end
    if (rd) begin
      b = mq.pop_front();
      got.push_back(b);
      if (b.last) m_pkts--;
    end
    if (wr) begin
      mq.push_back('{last: s_axis_tlast, data: s_axis_tdata});
      if (s_axis_tlast) m_pkts++;
    end
    last_wr = wr;
    cyc++;
    #1;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] data, input logic last);
    int n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    do begin
      cycle();
      n++;
    end while (!last_wr && n < 500);
    if (!last_wr) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: beat %h not accepted in %0d cycles", data, n);
    end else begin
      exp_q.push_back('{last: last, data: data});
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) cycle();
  endtask

  // Empties the buffer and compares the delivered stream against what was sent.
  task automatic drain(input int mode);
    int n = 0;
    ready_mode    = mode;
    s_axis_tvalid = 1'b0;
    while (mq.size() != 0 && n < 600) begin
      cycle();
      n++;
    end
    cycle();
    tests_run++;
    if (got.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL stream_len: got %0d beats expected %0d", got.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (got[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL stream beat %0d: got %h/%b expected %h/%b", i, got[i].data,
                   got[i].last, exp_q[i].data, exp_q[i].last);
        end
      end
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    tests_run++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 ||
        level !== '0 || pkt_count !== '0 || oversize_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_state: rdy %b vld %b last %b lvl %0d pkt %0d ovs %0d expected 1 0 0 0 0 0",
               s_axis_tready, m_axis_tvalid, m_axis_tlast, level, pkt_count, oversize_cnt);
    end
  endtask

  task automatic test_single();
    ready_mode = 1;
    for (int i = 1; i <= 4; i++) begin
      send_beat(DATA_W'(i), i == 4);
      tests_run++;
      if (m_axis_tvalid !== (i == 4)) begin
        tests_failed++;
        $display("FAIL single_valid beat %0d: got %b expected %b", i, m_axis_tvalid, i == 4);
      end
    end
    tests_run++;
    if (pkt_count !== CNT_W'(1)) begin
      tests_failed++;
      $display("FAIL single_pkt_count: got %0d expected 1", pkt_count);
    end
    drain(1);
    tests_run++;
    if (pkt_count !== '0) begin
      tests_failed++;
      $display("FAIL single_pkt_drained: got %0d expected 0", pkt_count);
    end
  endtask

  task automatic test_oscillate();
    ready_mode = 2;
    for (int p = 0; p < 5; p++)
      for (int b = 0; b < 3; b++) send_beat($urandom, b == 2);
    drain(2);
  endtask

  task automatic test_full();
    int n = 0;
    ready_mode = 0;
    for (int i = 1; i <= DEPTH; i++) send_beat(DATA_W'(32'h100 + i), i == DEPTH);
    tests_run++;
    if (s_axis_tready !== 1'b0 || level !== CNT_W'(DEPTH)) begin
      tests_failed++;
      $display("FAIL full: tready %b level %0d expected 0 and %0d", s_axis_tready, level, DEPTH);
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hABC;
    s_axis_tlast  = 1'b1;
    repeat (3) cycle();
    tests_run++;
    if (last_wr || level !== CNT_W'(DEPTH)) begin
      tests_failed++;
      $display("FAIL full_hold: level %0d expected %0d while beat 17 held", level, DEPTH);
    end
    ready_mode = 1;
    do begin
      cycle();
      n++;
    end while (!last_wr && n < 50);
    tests_run++;
    if (!last_wr) begin
      tests_failed++;
      $display("FAIL full_accept: beat 17 not accepted in %0d cycles", n);
    end else begin
      exp_q.push_back('{last: 1'b1, data: 32'hABC});
    end
    drain(1);
  endtask

  task automatic test_oversize();
    ready_mode = 0;
    for (int i = 1; i <= DEPTH; i++) send_beat($urandom, 1'b0);
    idle(2);
    tests_run++;
    if (oversize_cnt !== 16'd1 || m_axis_tvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL oversize_enter: ovs %0d vld %b expected 1 and 1", oversize_cnt, m_axis_tvalid);
    end
    ready_mode = 1;
    for (int i = DEPTH + 1; i <= 20; i++) send_beat($urandom, i == 20);
    drain(1);
    send_beat(32'h5555, 1'b0);
    idle(2);
    tests_run++;
    if (m_axis_tvalid !== 1'b0 || oversize_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL oversize_exit: vld %b ovs %0d expected 0 and 1", m_axis_tvalid, oversize_cnt);
    end
    send_beat(32'h6666, 1'b1);
    drain(1);
  endtask

  task automatic test_simul();
    ready_mode = 0;
    send_beat(32'hA1, 1'b1);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hB2;
    s_axis_tlast  = 1'b1;
    ready_mode    = 1;
    cycle();
    s_axis_tvalid = 1'b0;
    tests_run++;
    if (!last_wr || pkt_count !== CNT_W'(1) || level !== CNT_W'(1)) begin
      tests_failed++;
      $display("FAIL simul: pkt %0d level %0d expected 1 and 1", pkt_count, level);
    end
    if (last_wr) exp_q.push_back('{last: 1'b1, data: 32'hB2});
    drain(1);
  endtask

  task automatic test_reset_mid();
    ready_mode = 0;
    for (int i = 0; i < 7; i++) send_beat($urandom, 1'b0);
    tests_run++;
    if (level !== CNT_W'(7)) begin
      tests_failed++;
      $display("FAIL mid_level: got %0d expected 7", level);
    end
    #2;
    aresetn = 1'b0;
    #1;
    tests_run++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 ||
        level !== '0 || pkt_count !== '0 || oversize_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: rdy %b vld %b last %b lvl %0d pkt %0d ovs %0d expected 1 0 0 0 0 0",
               s_axis_tready, m_axis_tvalid, m_axis_tlast, level, pkt_count, oversize_cnt);
    end
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    ready_mode = 1;
    send_beat(32'hC0DE0001, 1'b0);
    send_beat(32'hC0DE0002, 1'b1);
    drain(1);
  endtask

  task automatic test_random();
    int len;
    ready_mode = 3;
    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(1, 22);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        send_beat($urandom, b == len - 1);
      end
    end
    drain(3);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    test_reset();
    test_single();
    test_oscillate();
    test_full();
    test_oversize();
    test_simul();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axis_pkt_fifo.md
# axis_pkt_fifo

Store-and-forward AXI4-Stream packet FIFO placed between the stream master VIP and the stream slave VIP in the `axis_vip_sim` block design. It buffers beats from the upstream master and presents a packet downstream only once that packet's TLAST beat is stored, so a throttling slave (oscillating TREADY) never sees a partial packet stall mid-burst. A fallback release mode prevents deadlock when a packet exceeds the buffer depth.

## Interface
Parameters:
- `DATA_W`, 32, TDATA width in bits (multiple of 8)
- `DEPTH`, 16, buffer entries; power of two, ≥ 4
- `CNT_W`, $clog2(DEPTH+1), width of occupancy and packet counters (derived, not overridden)

Ports (one clock; reset is asynchronous and active-low):
- `aclk`  in  1  clock, all logic on rising edge
- `aresetn`  in  1  asynchronous active-low reset
- `s_axis_tdata`  in  DATA_W  upstream data
- `s_axis_tvalid`  in  1  upstream valid
- `s_axis_tlast`  in  1  upstream end of packet
- `s_axis_tready`  out  1  buffer can accept a beat
- `m_axis_tdata`  out  DATA_W  downstream data
- `m_axis_tvalid`  out  1  downstream valid
- `m_axis_tlast`  out  1  downstream end of packet
- `m_axis_tready`  in  1  downstream ready
- `level`  out  CNT_W  beats currently stored
- `pkt_count`  out  CNT_W  complete packets (TLAST beats) stored
- `oversize_cnt`  out  16  saturating count of forced releases

## Operation
- Input handshake `wr = s_axis_tvalid & s_axis_tready`; output handshake `rd = m_axis_tvalid & m_axis_tready`.
- `s_axis_tready = (level != DEPTH)`; it depends only on registered state, never on `s_axis_tvalid`.
- On `wr`: store {tlast, tdata} at `wr_ptr`, then advance `wr_ptr`. On `rd`: advance `rd_ptr`. Pointers are log2(DEPTH)+1 bits; full/empty come from MSB compare, and the pointers wrap naturally.
- `level`: +1 on wr only, −1 on rd only, unchanged on both.
- `pkt_count`: +1 on wr with tlast, −1 on rd with tlast, unchanged when both occur in the same cycle.
- `m_axis_tvalid = !empty & (pkt_count != 0 | force_rel)`. `m_axis_tdata` and `m_axis_tlast` are the head entry, valid whenever `m_axis_tvalid` is high.
- Two-state release FSM:
  - STORE: output gated by `pkt_count`. Go to FORCE when `level == DEPTH` and `pkt_count == 0`; `oversize_cnt` +1, saturating at 16'hFFFF.
  - FORCE (`force_rel = 1`): beats stream cut-through. Return to STORE on the cycle after an `rd` with tlast.
- Once asserted, `m_axis_tvalid` does not deassert until `rd`. The gating above guarantees this, because `pkt_count` and FORCE only fall on an `rd`.
- Memory is a plain register array. It has no reset and no initialisation.

## Timing
- Reset (async assert, sync release): pointers 0, `level` 0, `pkt_count` 0, `oversize_cnt` 0, FSM STORE. Outputs: `s_axis_tready` 1, `m_axis_tvalid` 0, `m_axis_tlast` X-free 0 only through the gating (`m_axis_tdata` undefined).
- Latency: a TLAST beat accepted on edge N makes the packet head visible (`m_axis_tvalid` = 1) after edge N, i.e. 1 cycle.
- Full: a beat offered when `level == DEPTH` is not accepted. Simultaneous rd on a full buffer does not reopen `s_axis_tready` in that same cycle.
- Empty: `m_axis_tvalid` = 0 even in FORCE.
- Reset mid-packet discards all stored beats. Behaviour is identical to power-up.

## Structure
- Package `axis_pkt_pkg`: `typedef enum logic {ST_STORE, ST_FORCE} rel_state_t;` plus the entry struct `{logic last; logic [DATA_W-1:0] data;}`. The struct is parameterised via the module, so the package holds only the enum and the `OVERSIZE_MAX` constant.
- One sub-module, `axis_pkt_fifo_mem`: a DEPTH×(DATA_W+1) storage array with a synchronous write port and an asynchronous read port. Pointer, counter and FSM logic stay in the top level.

## Test plan
- Single 4-beat packet (0x1..0x4, last on 0x4), `m_axis_tready` = 1: `m_axis_tvalid` stays 0 for beats 1–3 and rises the cycle after 0x4 is accepted. Output is 0x1..0x4 back-to-back, `m_axis_tlast` only on 0x4, and `pkt_count` goes 1 → 0.
- Five 3-beat packets with the slave ready at low 2 / high 3 oscillating: all 15 beats arrive in order with TLAST on beats 3, 6, 9, 12, 15, and a stalled beat never changes.
- Fill to 16 beats with TLAST on beat 16, `m_axis_tready` = 0: `s_axis_tready` = 0 with `level` = 16. A 17th beat is held, then accepted once ready is raised, with no loss.
- 20-beat packet with `DEPTH` = 16: FORCE is entered at `level` 16 and `oversize_cnt` = 1. All 20 beats are delivered, and the FSM returns to STORE after beat 20.
- Simultaneous wr+rd of TLAST beats at `pkt_count` = 1: `pkt_count` stays 1 and `level` is unchanged.
- `aresetn` pulsed low mid-packet with 7 beats stored: outputs return to their reset values immediately, and a following 2-beat packet is delivered correctly.
